countdown_timer: RTL

- Loadable down-counter, the counting-down counterpart of the free-running step up-counter.
- Accepts a start value over a valid/ready handshake, then decrements by STEP per enabled cycle.
- Signals terminal count with a one-cycle done pulse, then stops or auto-reloads.
- Used as a programmable interval/timeout generator alongside the up-counter in the same DSP-friendly datapath.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 94 +++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the loadable down-counter.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } cd_state_t;

  // Widest counter the terminal test supports; narrower counts are zero-extended.
  localparam int unsigned CD_MAX_W = 64;

  function automatic logic is_terminal(input logic [CD_MAX_W-1:0] cnt,
                                       input logic [CD_MAX_W-1:0] step);
    return cnt <= step;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control and status bundle of the countdown timer.
interface countdown_timer_if #(
  parameter int unsigned W = 48
);
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic         en;
  logic         abort;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;

  modport master (
    output load_valid, load_value, auto_reload, en, abort,
    input  load_ready, cnt, busy, done
  );

  modport slave (
    input  load_valid, load_value, auto_reload, en, abort,
    output load_ready, cnt, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter by STEP with one-cycle done pulse; done ceil(V/STEP) enabled cycles after load.
// load_ready only in IDLE (loads elsewhere are dropped); en=0 stalls RUN, RELOAD ignores en.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned      W    = 48,
  parameter longint unsigned  STEP = 2
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  cd_state_t    state_q, state_d;
  logic         done_q, done_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;
  logic         terminal;

  assign terminal = is_terminal(CD_MAX_W'(cnt_q), CD_MAX_W'(STEP_W));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          cnt_d    = bus.load_value;
          reload_d = bus.load_value;
          // A zero load is already at terminal count: pulse done and stay idle.
          if (bus.load_value != '0) state_d = RUN;
          else                      done_d  = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.en) begin
          if (terminal) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = (bus.auto_reload && reload_q != '0) ? RELOAD : IDLE;
          end else begin
            cnt_d = cnt_q - STEP_W;
          end
        end
      end
      RELOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
          cnt_d   = reload_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.load_ready = (state_q == IDLE);

endmodule
